ps2_rx_ctrl: RTL
================

// Module: ps2_rx_ctrl
// PURPOSE
//  Sequences PS/2 keyboard reception in the FPGAClk domain for the calculator front end.
//  Synchronizes PS2Clk/PS2Data, frames 11-bit packets (start, 8 data LSB-first, odd parity, stop),
//  decodes E0/F0 prefixes and queues complete key events in a small FIFO.
//  Downstream key decoder pops events via valid/ready; errors and overflow are flagged.
// PARAMETERS
//  SYNC_STAGES  2      flops per input synchronizer (>=2)
//  TIMEOUT_CYC  15000  FPGAClk cycles without a PS2Clk fall before an in-progress frame is aborted
//  FIFO_DEPTH   4      key-event FIFO entries (power of 2, >=2)
// PORTS
//  FPGAClk     in   1  system clock; all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  PS2Clk      in   1  raw PS/2 clock from keyboard (asynchronous)
//  PS2Data     in   1  raw PS/2 data from keyboard (asynchronous)
//  en          in   1  receive enable; 0 forces IDLE, FIFO still drains
//  key_code    out  8  scan code at FIFO head
//  key_ext     out  1  head event was prefixed by E0
//  key_break   out  1  head event was prefixed by F0 (key release)
//  key_valid   out  1  FIFO non-empty
//  key_ready   in   1  consumer accepts head when key_valid & key_ready
//  frame_err   out  1  one-cycle pulse on start/parity/stop/timeout error
//  fifo_ovf    out  1  sticky: event dropped on full FIFO; cleared only by rst
//  busy        out  1  frame in progress (state != IDLE)
//  bit_cnt     out  4  data bits received in current frame (debug)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; prefix flags clear; synchronizer flops reset to 1 (bus idle high)
//   so reset release never produces a false edge.
//  Edge detect: fall = prev_sync_clk & ~sync_clk; PS2Data sampled (synchronized) in the fall cycle.
//  FSM (advances only on fall cycles, except timeout/en):
//   IDLE : fall & data==0 -> DATA, bit_cnt=0; fall & data==1 -> stay IDLE, frame_err pulse
//   DATA : shift data into bit7, shreg>>1; bit_cnt++; after 8th bit -> PAR
//   PAR  : capture parity bit -> STOP
//   STOP : data==1 & ^{shreg,par}==1 -> IDLE + byte accepted; otherwise -> IDLE, frame_err pulse
//  Watchdog: counter cleared on every fall and in IDLE; reaching TIMEOUT_CYC in a non-IDLE state
//   -> IDLE, frame_err pulse, bit_cnt=0, prefix flags cleared.
//  en=0: FSM held in IDLE, watchdog cleared, falls ignored; partial frame discarded (no error).
//  Byte accepted: E0 sets ext flag; F0 sets brk flag; neither is pushed.
//   Any other byte pushes {ext,brk,byte} and clears both flags. Any error also clears both flags.
//  Latency: key_valid rises exactly 1 cycle after the stop-bit fall cycle when the FIFO was empty.
//  FIFO: first-word-fall-through; head on key_code/key_ext/key_break; pop on key_valid & key_ready.
//   Push while full and no pop: event dropped, fifo_ovf set.
//   Push while full with simultaneous pop: both happen, no overflow.
//   Pop on empty: ignored. Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  Reset mid-frame: FSM, FIFO, flags and watchdog cleared next edge; the resumed frame is rejected
//   via start/timeout checks.
// TESTING
//  1. Send 0x1C with parity=0, stop=1, key_ready=1 -> one event code=1C ext=0 brk=0,
//     key_valid 1 cycle after the stop fall.
//  2. Send F0,1C then E0,F0,75 -> events {1C,ext0,brk1} and {75,ext1,brk1}; no prefix-only events.
//  3. Send 0x1C with a bad parity bit, then a frame with stop=0 -> two frame_err pulses,
//     FIFO empty, flags clear.
//  4. Stop PS2Clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err at count TIMEOUT_CYC,
//     busy=0; next valid frame is received correctly.
//  5. key_ready=0, send 5 codes -> 4 buffered, fifo_ovf=1; drain -> first 4 codes in order.
//     With FIFO full, pop and push in the same cycle -> fifo_ovf stays 0.
//  6. Assert rst during bit 5 of a frame -> all outputs 0 next cycle, no spurious event.
//     Deassert en mid-frame -> frame discarded, no frame_err.

Source files
------------

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receiver: synchronizer, 11-bit framer, E0/F0 prefix decode
// and a small first-word-fall-through key-event FIFO in the FPGAClk domain.
module ps2_rx_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 15000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       FPGAClk,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       en,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       fifo_ovf,
  output logic       busy,
  output logic [3:0] bit_cnt
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int WW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   fall;
  logic                   din;

  state_t        state;
  logic [7:0]    shreg;
  logic          par;
  logic          ext_f;
  logic          brk_f;
  logic [WW-1:0] wd;
  logic          tout;
  logic          stop_ok;
  logic          push;
  ev_t           push_ev;

  ev_t           mem [FIFO_DEPTH];
  ev_t           head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;

  // Flops reset high so releasing reset never looks like a clock fall.
  always_ff @(posedge FPGAClk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2Data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign din  = dat_sync[SYNC_STAGES-1];
  assign fall = en & clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign tout = (state != IDLE) & ~fall & (wd == WD_LAST);

  assign stop_ok = (state == STOP) & fall & din & (^{shreg, par});
  assign push    = stop_ok & (shreg != 8'hE0) & (shreg != 8'hF0);
  assign push_ev = {ext_f, brk_f, shreg};

  always_ff @(posedge FPGAClk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      par       <= 1'b0;
      bit_cnt   <= '0;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      wd        <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        wd      <= '0;
        bit_cnt <= '0;
      end else if (tout) begin
        state     <= IDLE;
        wd        <= '0;
        bit_cnt   <= '0;
        frame_err <= 1'b1;
        ext_f     <= 1'b0;
        brk_f     <= 1'b0;
      end else begin
        if (fall || state == IDLE) begin
          wd <= '0;
        end else begin
          wd <= wd + 1'b1;
        end
        if (fall) begin
          unique case (state)
            IDLE: begin
              if (!din) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
                ext_f     <= 1'b0;
                brk_f     <= 1'b0;
              end
            end
            DATA: begin
              shreg   <= {din, shreg[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= PAR;
              end
            end
            PAR: begin
              par   <= din;
              state <= STOP;
            end
            STOP: begin
              state   <= IDLE;
              bit_cnt <= '0;
              if (stop_ok) begin
                if (shreg == 8'hE0) begin
                  ext_f <= 1'b1;
                end else if (shreg == 8'hF0) begin
                  brk_f <= 1'b1;
                end else begin
                  ext_f <= 1'b0;
                  brk_f <= 1'b0;
                end
              end else begin
                frame_err <= 1'b1;
                ext_f     <= 1'b0;
                brk_f     <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign busy = (state != IDLE);

  assign full      = (count == DEPTH);
  assign key_valid = (count != '0);
  assign pop       = key_valid & key_ready;
  assign wr_en     = push & (~full | pop);
  assign head      = mem[rd_ptr];

  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_ext   = key_valid & head.ext;
  assign key_break = key_valid & head.brk;

  always_ff @(posedge FPGAClk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_ev;
    end
  end

  always_ff @(posedge FPGAClk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (!wr_en && pop) begin
        count <= count - 1'b1;
      end
      if (push && !wr_en) begin
        fifo_ovf <= 1'b1;
      end
    end
  end

endmodule
